// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and access-size / alignment helpers.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes (illegal codes map to 3, caught by f3_legal)
  function automatic logic [1:0] size_lg(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_lg = 2'd0;
      F3_H, F3_HU: size_lg = 2'd1;
      F3_W, F3_WU: size_lg = 2'd2;
      default:     size_lg = 2'd3;
    endcase
  endfunction

  // doubleword and unsigned-word forms only exist on a 64-bit datapath
  function automatic logic f3_legal(input logic [2:0] f3, input logic is64);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      F3_D, F3_WU:                    f3_legal = is64;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

  // byte-enable mask for the access size, before shifting to the lane offset
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (size_lg(f3))
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // unknown encodings are reported the same way as misaligned addresses
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [2:0] off,
                                          input logic is64);
    logic mis;
    case (size_lg(f3))
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off[2:0];
    endcase
    lsu_misaligned = mis | ~f3_legal(f3, is64);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the addressed bytes down to lane 0, keep the
// access size and sign- or zero-extend to the full datapath width.
module lsu_load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             i_rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   i_off,
  input  logic [2:0]                    i_funct3,
  output logic [DATA_W-1:0]             o_data
);

  logic [DATA_W-1:0] w_shift;
  logic [1:0]        w_lg;
  logic              w_ext;

  assign w_shift = i_rdata >> {i_off, 3'b000};
  assign w_lg    = size_lg(i_funct3);

  // extension bit: top bit of the accessed field, forced to 0 for unsigned loads
  always_comb begin
    case (w_lg)
      2'd0:    w_ext = w_shift[7];
      2'd1:    w_ext = w_shift[15];
      2'd2:    w_ext = w_shift[31];
      default: w_ext = w_shift[DATA_W-1];
    endcase
    w_ext = w_ext & ~i_funct3[2];
  end

  // replace every bit above the access size with the extension bit
  always_comb begin
    o_data = w_shift;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= (8 << w_lg)) o_data[i] = w_ext;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit towards a req/gnt/rvalid data memory
// plus the MEM/WB register. Upstream is stalled while an access is in flight.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  mem_we,
  input  logic                  mem_re,
  input  logic [2:0]            funct3,
  input  logic                  branch_instruction,
  input  logic                  branch_in,
  input  logic                  reg_file_write_in,
  input  logic [ADDR_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     reg_out_b,
  input  logic [ADDR_W-1:0]     add_pc_in,
  input  logic [SEL_W-1:0]      select_mux_2_in,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [DATA_W/8-1:0]   dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  valid_out,
  output logic                  reg_file_write_out,
  output logic [DATA_W-1:0]     mem_out,
  output logic [ADDR_W-1:0]     add_pc_out,
  output logic [ADDR_W-1:0]     alu_result_out,
  output logic [SEL_W-1:0]      select_mux_2_out,
  output logic                  pc_src_out,
  output logic                  misaligned_out
);

  localparam int   NB    = DATA_W / 8;
  localparam int   OFF_W = $clog2(NB);
  localparam logic IS64  = (DATA_W == 64);

  lsu_state_e        r_state, w_next;

  // captured instruction while the access is outstanding
  logic [ADDR_W-1:0] r_alu;
  logic [ADDR_W-1:0] r_pc;
  logic [SEL_W-1:0]  r_sel;
  logic              r_pcsrc;
  logic              r_rfw;
  logic              r_store;
  logic [2:0]        r_f3;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ldata;

  logic              w_mem_op;
  logic              w_mis;
  logic              w_start;
  logic              w_stall;
  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_lg;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ldata;

  assign w_mem_op = valid_in & (mem_we | mem_re);
  assign w_off    = alu_out[OFF_W-1:0];
  assign w_mis    = lsu_misaligned(funct3, 3'(w_off), IS64);
  assign w_start  = w_mem_op & ~w_mis;
  assign w_lg     = size_lg(funct3);
  assign w_be     = NB'(size_mask(funct3)) << w_off;

  // replicate the low access-size bytes of the store data into every lane
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      w_wdata[8*i +: 8] = reg_out_b[8*(i & ((1 << w_lg) - 1)) +: 8];
    end
  end

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .i_rdata  (dmem_rdata),
    .i_off    (r_alu[OFF_W-1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_ldata)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state; a read response arriving with the grant is not accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ:  if (dmem_gnt) w_next = r_store ? ST_DONE : ST_RESP;
      ST_RESP: if (dmem_rvalid) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stall covers the accept cycle through the response cycle
  always_comb begin
    w_stall  = 1'b0;
    dmem_req = 1'b0;
    case (r_state)
      ST_IDLE: w_stall = w_start;
      ST_REQ:  begin w_stall = 1'b1; dmem_req = 1'b1; end
      ST_RESP: w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  // inputs may still show a memory op while reset is held
  assign stall      = reset & w_stall;
  assign dmem_we    = r_store;
  assign dmem_addr  = {r_alu[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;

  // request capture, load data capture and the MEM/WB register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu              <= '0;
      r_pc               <= '0;
      r_sel              <= '0;
      r_pcsrc            <= 1'b0;
      r_rfw              <= 1'b0;
      r_store            <= 1'b0;
      r_f3               <= '0;
      r_be               <= '0;
      r_wdata            <= '0;
      r_ldata            <= '0;
      valid_out          <= 1'b0;
      reg_file_write_out <= 1'b0;
      mem_out            <= '0;
      add_pc_out         <= '0;
      alu_result_out     <= '0;
      select_mux_2_out   <= '0;
      pc_src_out         <= 1'b0;
      misaligned_out     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_alu              <= alu_out;
            r_pc               <= add_pc_in;
            r_sel              <= select_mux_2_in;
            r_pcsrc            <= branch_instruction & branch_in;
            r_rfw              <= reg_file_write_in;
            r_store            <= mem_we;
            r_f3               <= funct3;
            r_be               <= w_be;
            r_wdata            <= w_wdata;
            valid_out          <= 1'b0;
            reg_file_write_out <= 1'b0;
            pc_src_out         <= 1'b0;
            misaligned_out     <= 1'b0;
          end else begin
            // plain ALU op, or a memory op rejected for alignment
            valid_out          <= valid_in;
            reg_file_write_out <= valid_in & reg_file_write_in & ~w_mem_op;
            mem_out            <= '0;
            add_pc_out         <= add_pc_in;
            alu_result_out     <= alu_out;
            select_mux_2_out   <= select_mux_2_in;
            pc_src_out         <= branch_instruction & branch_in;
            misaligned_out     <= w_mem_op;
          end
        end
        ST_RESP: begin
          if (dmem_rvalid) r_ldata <= w_ldata;
          valid_out          <= 1'b0;
          reg_file_write_out <= 1'b0;
          pc_src_out         <= 1'b0;
          misaligned_out     <= 1'b0;
        end
        ST_DONE: begin
          valid_out          <= 1'b1;
          reg_file_write_out <= r_rfw & ~r_store;
          mem_out            <= r_store ? '0 : r_ldata;
          add_pc_out         <= r_pc;
          alu_result_out     <= r_alu;
          select_mux_2_out   <= r_sel;
          pc_src_out         <= r_pcsrc;
          misaligned_out     <= 1'b0;
        end
        default: begin
          valid_out          <= 1'b0;
          reg_file_write_out <= 1'b0;
          pc_src_out         <= 1'b0;
          misaligned_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit and a 64-bit instance share the upstream
// buses; a byte-array memory answers the dmem port and a second byte array
// holds the architectural memory image used to predict load results.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v32, v64, mem_we, mem_re, bi, br, rfw;
  logic [2:0]  funct3;
  logic [31:0] alu_out, add_pc_in;
  logic [63:0] reg_out_b;
  logic [1:0]  sel_in;
  logic        gnt, rvalid;
  logic [63:0] rdata;

  logic        stall32, req32, we32, vo32, rfwo32, pcs32, mis32;
  logic [31:0] addr32, wdata32, memo32, pco32, aluo32;
  logic [3:0]  be32;
  logic [1:0]  selo32;

  logic        stall64, req64, we64, vo64, rfwo64, pcs64, mis64;
  logic [31:0] addr64, pco64, aluo64;
  logic [63:0] wdata64, memo64;
  logic [7:0]  be64;
  logic [1:0]  selo64;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .SEL_W(2)) u_dut (
    .clk(clk), .reset(reset), .valid_in(v32), .mem_we(mem_we), .mem_re(mem_re),
    .funct3(funct3), .branch_instruction(bi), .branch_in(br), .reg_file_write_in(rfw),
    .alu_out(alu_out), .reg_out_b(reg_out_b[31:0]), .add_pc_in(add_pc_in),
    .select_mux_2_in(sel_in), .stall(stall32), .dmem_req(req32), .dmem_we(we32),
    .dmem_addr(addr32), .dmem_wdata(wdata32), .dmem_be(be32), .dmem_gnt(gnt),
    .dmem_rvalid(rvalid), .dmem_rdata(rdata[31:0]), .valid_out(vo32),
    .reg_file_write_out(rfwo32), .mem_out(memo32), .add_pc_out(pco32),
    .alu_result_out(aluo32), .select_mux_2_out(selo32), .pc_src_out(pcs32),
    .misaligned_out(mis32));

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .SEL_W(2)) u_dut64 (
    .clk(clk), .reset(reset), .valid_in(v64), .mem_we(mem_we), .mem_re(mem_re),
    .funct3(funct3), .branch_instruction(bi), .branch_in(br), .reg_file_write_in(rfw),
    .alu_out(alu_out), .reg_out_b(reg_out_b), .add_pc_in(add_pc_in),
    .select_mux_2_in(sel_in), .stall(stall64), .dmem_req(req64), .dmem_we(we64),
    .dmem_addr(addr64), .dmem_wdata(wdata64), .dmem_be(be64), .dmem_gnt(gnt),
    .dmem_rvalid(rvalid), .dmem_rdata(rdata), .valid_out(vo64),
    .reg_file_write_out(rfwo64), .mem_out(memo64), .add_pc_out(pco64),
    .alu_result_out(aluo64), .select_mux_2_out(selo64), .pc_src_out(pcs64),
    .misaligned_out(mis64));

  // view of whichever instance is under test
  bit          use64;
  logic        s_stall, s_req, s_we, s_vo, s_rfw, s_pcs, s_mis;
  logic [31:0] s_addr, s_pc, s_alu;
  logic [63:0] s_wdata, s_mem;
  logic [7:0]  s_be;
  logic [1:0]  s_sel;

  always_comb begin
    if (use64) begin
      s_stall = stall64; s_req = req64; s_we = we64; s_vo = vo64; s_rfw = rfwo64;
      s_pcs = pcs64; s_mis = mis64; s_addr = addr64; s_pc = pco64; s_alu = aluo64;
      s_wdata = wdata64; s_mem = memo64; s_be = be64; s_sel = selo64;
    end else begin
      s_stall = stall32; s_req = req32; s_we = we32; s_vo = vo32; s_rfw = rfwo32;
      s_pcs = pcs32; s_mis = mis32; s_addr = addr32; s_pc = pco32; s_alu = aluo32;
      s_wdata = {32'h0, wdata32}; s_mem = {32'h0, memo32}; s_be = {4'h0, be32};
      s_sel = selo32;
    end
  end

  logic [7:0] rmem [512];   // contents seen through the dmem port
  logic [7:0] mmem [512];   // architectural image predicted from the instruction stream

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // issue one instruction, play the memory side, and check it end to end
  task automatic run_op(input bit w64, input bit we, input bit re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] data,
                        input bit bi_, input bit br_, input bit rfw_,
                        input logic [31:0] pc, input logic [1:0] sel,
                        input int gw, input int rw);
    int nb, n, base, lat, cyc, stall_n, req_n, gcnt, rcnt;
    bit memop, st, mis, rpend, reqseen, got;
    logic [63:0] exp_ld, bexp, wexp;
    logic [31:0] abase;
    nb = w64 ? 8 : 4;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      3'd6:       n = w64 ? 4 : 0;
      3'd3:       n = w64 ? 8 : 0;
      default:    n = 0;
    endcase
    memop = we || re;
    st    = we;
    mis   = memop && (n == 0 || (addr % n) != 0);
    lat   = (!memop || mis) ? 1 : (st ? gw + 3 : gw + rw + 4);
    base  = int'(addr % nb);
    abase = addr - base;
    exp_ld = '0; bexp = '0; wexp = '0;
    if (memop && !mis) begin
      for (int b = 0; b < n; b++) exp_ld |= 64'(mmem[(addr + b) % 512]) << (8 * b);
      if (!f3[2] && n < 8 && exp_ld[8*n-1]) exp_ld |= ~64'h0 << (8 * n);
      if (!w64) exp_ld &= 64'hFFFF_FFFF;
      bexp = ((64'd1 << n) - 1) << base;
      for (int i = 0; i < nb; i++) wexp[8*i +: 8] = data[8*(i % n) +: 8];
      if (st) for (int b = 0; b < n; b++) mmem[(addr + b) % 512] = data[8*b +: 8];
    end
    use64 = w64;
    v32 = !w64; v64 = w64; mem_we = we; mem_re = re; funct3 = f3; alu_out = addr;
    reg_out_b = data; bi = bi_; br = br_; rfw = rfw_; add_pc_in = pc; sel_in = sel;
    #1;
    cyc = 0; stall_n = 0; req_n = 0; gcnt = gw; rcnt = 0;
    rpend = 0; reqseen = 0; got = 0;
    while (cyc < 80) begin
      if (cyc > 0 && s_vo) begin got = 1; break; end
      if (s_stall) stall_n++;
      if (s_req) begin
        req_n++;
        if (!reqseen) begin
          reqseen = 1;
          chk("req_addr", 64'(s_addr), 64'(abase));
          chk("req_be", 64'(s_be), bexp);
          chk("req_we", 64'(s_we), 64'(st));
          if (st) chk("req_wdata", s_wdata, wexp);
        end
        if (gcnt == 0) begin
          gnt = 1'b1;
          if (st) begin
            for (int i = 0; i < nb; i++)
              if (s_be[i]) rmem[(abase + i) % 512] = s_wdata[8*i +: 8];
          end else begin
            rpend = 1; rcnt = rw;
          end
          // a response in the grant cycle must be ignored
          if ($urandom_range(1, 0) == 1) begin rvalid = 1'b1; rdata = {$urandom, $urandom}; end
        end else gcnt--;
      end else if (rpend) begin
        if (rcnt == 0) begin
          rvalid = 1'b1;
          for (int i = 0; i < nb; i++) rdata[8*i +: 8] = rmem[(abase + i) % 512];
          rpend = 0;
        end else begin
          rcnt--;
          rdata = {$urandom, $urandom};
        end
      end
      @(negedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0;
      cyc++;
    end
    chk("valid_out_seen", 64'(got), 64'd1);
    if (got) begin
      chk("latency", 64'(cyc), 64'(lat));
      chk("misaligned_out", 64'(s_mis), 64'(mis));
      chk("rf_write_out", 64'(s_rfw), 64'(rfw_ && !mis && !(memop && st)));
      chk("pc_src_out", 64'(s_pcs), 64'(bi_ && br_));
      chk("add_pc_out", 64'(s_pc), 64'(pc));
      chk("alu_result_out", 64'(s_alu), 64'(addr));
      chk("sel_out", 64'(s_sel), 64'(sel));
      if (memop && !st && !mis) chk("mem_out", s_mem, exp_ld);
    end
    chk("stall_cycles", 64'(stall_n), 64'((memop && !mis) ? lat - 1 : 0));
    chk("req_cycles", 64'(req_n), 64'((memop && !mis) ? gw + 1 : 0));
  endtask

  task automatic rand_op(input bit w64);
    int kind;
    logic [2:0] f3;
    logic [31:0] a;
    kind = $urandom_range(3, 0);
    f3 = 3'($urandom_range(7, 0));
    if (!w64 && (f3 == 3'd3 || f3 >= 3'd6) && $urandom_range(3, 0) != 0) f3 = 3'd2;
    a = 32'h100 + $urandom_range(255, 0);
    if ($urandom_range(3, 0) != 0) a[2:0] = 3'd0;
    run_op(w64, kind >= 2, kind == 1 || kind == 3, f3, a, {$urandom, $urandom},
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           $urandom, 2'($urandom_range(3, 0)), $urandom_range(3, 0), $urandom_range(3, 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; use64 = 0;
    v32 = 0; v64 = 0; mem_we = 0; mem_re = 0; funct3 = 0; bi = 0; br = 0; rfw = 0;
    alu_out = 0; add_pc_in = 0; reg_out_b = 0; sel_in = 0; gnt = 0; rvalid = 0; rdata = 0;
    for (int i = 0; i < 512; i++) begin
      rmem[i] = 8'($urandom);
      mmem[i] = rmem[i];
    end
    #1;
    chk("rst_valid_out", 64'(vo32), 64'd0);
    chk("rst_stall", 64'(stall32), 64'd0);
    chk("rst_req", 64'(req32), 64'd0);
    chk("rst_mem_out", 64'(memo32), 64'd0);
    chk("rst_pc_src", 64'(pcs32), 64'd0);
    chk("rst_misaligned", 64'(mis32), 64'd0);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1;

    // word and byte stores, then loads of the half-word pattern 0x0080FF00
    run_op(0, 1, 0, 3'b010, 32'h100, 64'hDEADBEEF, 0, 0, 0, 32'h104, 2'd1, 2, 0);
    run_op(0, 1, 0, 3'b000, 32'h103, 64'h000000AB, 0, 0, 0, 32'h108, 2'd0, 0, 0);
    run_op(0, 1, 0, 3'b010, 32'h100, 64'h0080FF00, 0, 0, 0, 32'h10C, 2'd0, 0, 0);
    run_op(0, 0, 1, 3'b000, 32'h102, 64'h0, 0, 0, 1, 32'h110, 2'd2, 1, 1);
    chk("lb_0x102", s_mem, 64'hFFFF_FF80);
    run_op(0, 0, 1, 3'b100, 32'h102, 64'h0, 0, 0, 1, 32'h114, 2'd2, 0, 0);
    chk("lbu_0x102", s_mem, 64'h0000_0080);
    run_op(0, 0, 1, 3'b001, 32'h102, 64'h0, 0, 0, 1, 32'h118, 2'd2, 0, 2);
    chk("lh_0x102", s_mem, 64'h0000_0080);

    // misaligned word load, then ALU ops including taken / not-taken branches
    run_op(0, 0, 1, 3'b010, 32'h101, 64'h0, 0, 0, 1, 32'h11C, 2'd2, 0, 0);
    run_op(0, 0, 0, 3'b000, 32'h300, 64'h0, 0, 0, 1, 32'h4000, 2'd0, 0, 0);
    run_op(0, 0, 0, 3'b000, 32'h304, 64'h0, 1, 1, 0, 32'h4004, 2'd3, 0, 0);
    run_op(0, 0, 0, 3'b000, 32'h308, 64'h0, 1, 0, 0, 32'h4008, 2'd3, 0, 0);

    // reset while a load waits for its response
    use64 = 0;
    v32 = 1; mem_we = 0; mem_re = 1; funct3 = 3'b010; alu_out = 32'h100; rfw = 1;
    @(negedge clk); #1 gnt = 1'b1;
    @(negedge clk); #1 gnt = 1'b0;
    chk("resp_stall", 64'(s_stall), 64'd1);
    chk("resp_req", 64'(s_req), 64'd0);
    reset = 1'b0;
    #1;
    chk("midrst_stall", 64'(s_stall), 64'd0);
    chk("midrst_req", 64'(s_req), 64'd0);
    chk("midrst_valid", 64'(s_vo), 64'd0);
    chk("midrst_alu_out", 64'(s_alu), 64'd0);
    chk("midrst_pc_out", 64'(s_pc), 64'd0);
    v32 = 0; mem_re = 0;
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 rvalid = 1'b1; rdata = {$urandom, $urandom};
    @(negedge clk); #1 rvalid = 1'b0;
    chk("late_rvalid_valid", 64'(s_vo), 64'd0);
    chk("late_rvalid_stall", 64'(s_stall), 64'd0);
    @(negedge clk); #1;
    chk("late_rvalid_valid2", 64'(s_vo), 64'd0);

    for (int k = 0; k < 40; k++) rand_op(0);

    // 64-bit datapath: doubleword store/load and the unsigned word load
    run_op(1, 1, 0, 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 32'h200, 2'd1, 1, 0);
    run_op(1, 0, 1, 3'b011, 32'h8, 64'h0, 0, 0, 1, 32'h204, 2'd1, 0, 1);
    chk("ld_0x8", s_mem, 64'h0123_4567_89AB_CDEF);
    run_op(1, 0, 1, 3'b110, 32'hC, 64'h0, 0, 0, 1, 32'h208, 2'd1, 0, 0);
    chk("lwu_0xc", s_mem, 64'h0000_0000_0123_4567);
    run_op(1, 0, 1, 3'b010, 32'h8, 64'h0, 0, 0, 1, 32'h20C, 2'd1, 2, 0);
    chk("lw_0x8", s_mem, 64'hFFFF_FFFF_89AB_CDEF);
    run_op(1, 0, 1, 3'b011, 32'h4, 64'h0, 0, 0, 1, 32'h210, 2'd1, 0, 0);
    for (int k = 0; k < 30; k++) rand_op(1);

    v32 = 0; v64 = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
